// File: rtl/mpadd_word_add.sv
// One word of a multi-precision add/subtract: optional B inversion, carry-in,
// carry-out and signed overflow for the word's MSB.
module mpadd_word_add #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   full;

  always_comb begin
    b_eff = sub ? ~b : b;
    full  = {1'b0, a} + {1'b0, b_eff} + (WIDTH + 1)'(cin);
    sum   = full[WIDTH-1:0];
    cout  = full[WIDTH];
    // Signed overflow only matters for the top word, but is cheap to form per word.
    ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  end

endmodule

// File: rtl/mpadd_seq.sv
// Streaming multi-precision adder/subtractor: LS word first, carry chained
// across words through a register, one registered result word per accept.
module mpadd_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_last,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic [CNT_W-1:0] out_idx,
  output logic             out_cout,
  output logic             out_ovf
);

  typedef enum logic {StFirst, StMid} state_t;

  state_t           state;
  logic             carry;
  logic             sub_r;
  logic             accept;
  logic             first;
  logic             sub_sel;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign first    = (state == StFirst);
  // The first word takes mode live from the input; later words use the latched mode.
  assign sub_sel  = first ? in_sub : sub_r;
  assign cin      = first ? in_sub : carry;

  mpadd_word_add #(
    .WIDTH(WIDTH)
  ) u_word_add (
    .a   (in_a),
    .b   (in_b),
    .sub (sub_sel),
    .cin (cin),
    .sum (sum),
    .cout(cout),
    .ovf (ovf)
  );

  always_ff @(posedge clk) begin
    if (srst) begin
      state     <= StFirst;
      carry     <= 1'b0;
      sub_r     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_idx   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
    end else if (accept) begin
      carry     <= cout;
      if (first) sub_r <= in_sub;
      state     <= in_last ? StFirst : StMid;
      out_valid <= 1'b1;
      out_data  <= sum;
      out_last  <= in_last;
      // out_idx doubles as the word counter; wraps silently.
      out_idx   <= first ? '0 : out_idx + 1'b1;
      out_cout  <= in_last && cout;
      out_ovf   <= in_last && ovf;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mpadd_seq.sv
// Randomized bench for mpadd_seq: packets modelled as whole integers, results
// scoreboarded word by word, plus directed corner cases.
module tb_mpadd_seq;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             srst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic             in_last = 1'b0;
  logic             in_sub = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic [CNT_W-1:0] out_idx;
  logic             out_cout;
  logic             out_ovf;

  always #5 clk = ~clk;

  mpadd_seq #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .srst     (srst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_last  (in_last),
    .in_sub   (in_sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .out_idx  (out_idx),
    .out_cout (out_cout),
    .out_ovf  (out_ovf)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [3:0] idx;
    logic       cout;
    logic       ovf;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] pa[20];
  logic [7:0] pb[20];
  int         n_checks = 0;
  int         n_errors = 0;
  bit         rand_ready = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Whole-integer reference: packets up to 7 words are done as 56-bit arithmetic;
  // longer packets are only ever sent with B = 0, so the result is A itself.
  task automatic model_packet(input int n, input logic sub);
    longint a_v, b_v, full, half, r, sa, sb, sr;
    logic   cout, ovf;
    exp_t   e;
    if (n <= 7) begin
      a_v = 0;
      b_v = 0;
      for (int i = n - 1; i >= 0; i--) begin
        a_v = (a_v << 8) | longint'(pa[i]);
        b_v = (b_v << 8) | longint'(pb[i]);
      end
      full = longint'(1) << (8 * n);
      half = full >> 1;
      r    = sub ? a_v - b_v : a_v + b_v;
      cout = sub ? (a_v >= b_v) : (r >= full);
      r    = r & (full - 1);
      sa   = (a_v >= half) ? a_v - full : a_v;
      sb   = (b_v >= half) ? b_v - full : b_v;
      sr   = sub ? sa - sb : sa + sb;
      ovf  = (sr < -half) || (sr >= half);
      for (int i = 0; i < n; i++) begin
        e.data = 8'((r >> (8 * i)) & 255);
        e.last = (i == n - 1);
        e.idx  = 4'(i % 16);
        e.cout = e.last && cout;
        e.ovf  = e.last && ovf;
        exp_q.push_back(e);
      end
    end else begin
      for (int i = 0; i < n; i++) begin
        e.data = pa[i];
        e.last = (i == n - 1);
        e.idx  = 4'(i % 16);
        e.cout = e.last && sub;
        e.ovf  = 1'b0;
        exp_q.push_back(e);
      end
    end
  endtask

  // Returns at posedge+1 of the accepting edge.
  task automatic send_word(input logic [7:0] a, input logic [7:0] b, input logic last,
                           input logic sub);
    int waited = 0;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    in_sub   = sub;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 500) begin
        $display("FAIL in_ready_timeout: got 0 expected 1");
        $fatal(1, "input handshake stuck");
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // rest_mode: 0/1 drives that in_sub on later words, 2 drives random.
  task automatic send_packet(input int n, input logic sub, input int rest_mode, input int gaps);
    logic s;
    model_packet(n, sub);
    for (int i = 0; i < n; i++) begin
      s = (i == 0) ? sub : (rest_mode == 2) ? logic'($urandom_range(0, 1)) : logic'(rest_mode);
      send_word(pa[i], pb[i], (i == n - 1), s);
      if (gaps > 0) repeat ($urandom_range(0, gaps)) @(posedge clk);
      if (gaps > 0) #1;
    end
  endtask

  // Scoreboard plus hold-stability monitor, sampled mid-cycle.
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data;
  logic [7:0] prev_side;
  always @(negedge clk) begin
    exp_t e;
    if (srst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(prev_data));
        check("hold_side", 32'({out_last, out_idx, out_cout, out_ovf}), 32'(prev_side));
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      prev_side = {1'b0, out_last, out_idx, out_cout, out_ovf};
      if (out_valid && out_ready) begin
        check("q_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("out_data", 32'(out_data), 32'(e.data));
          check("out_last", 32'(out_last), 32'(e.last));
          check("out_idx", 32'(out_idx), 32'(e.idx));
          check("out_cout", 32'(out_cout), 32'(e.cout));
          check("out_ovf", 32'(out_ovf), 32'(e.ovf));
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] snap;
    int         waited;

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_side", 32'({out_last, out_idx, out_cout, out_ovf}), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    srst = 1'b0;

    // Single word carry out, checked at one-cycle latency.
    pa[0] = 8'hFF; pb[0] = 8'h01;
    send_packet(1, 1'b0, 0, 0);
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_data", 32'(out_data), 32'h00);
    check("t1_flags", 32'({out_last, out_idx, out_cout, out_ovf}), 32'b1_0000_1_0);

    pa[0] = 8'hFF; pb[0] = 8'h01; pa[1] = 8'h01; pb[1] = 8'h00;
    send_packet(2, 1'b0, 0, 0);
    check("t2_data", 32'(out_data), 32'h02);
    check("t2_flags", 32'({out_last, out_idx, out_cout, out_ovf}), 32'b1_0001_0_0);

    // Second word must stay in subtract mode with in_sub low.
    pa[0] = 8'h00; pb[0] = 8'h01; pa[1] = 8'h01; pb[1] = 8'h00;
    send_packet(2, 1'b1, 0, 0);
    check("t3_data", 32'(out_data), 32'h00);
    check("t3_flags", 32'({out_last, out_idx, out_cout, out_ovf}), 32'b1_0001_1_0);

    pa[0] = 8'h7F; pb[0] = 8'h01;
    send_packet(1, 1'b0, 0, 0);
    check("t4a_data", 32'(out_data), 32'h80);
    check("t4a_flags", 32'({out_cout, out_ovf}), 32'b0_1);
    pa[0] = 8'h80; pb[0] = 8'h01;
    send_packet(1, 1'b1, 0, 0);
    check("t4b_data", 32'(out_data), 32'h7F);
    check("t4b_flags", 32'({out_cout, out_ovf}), 32'b1_1);

    // Backpressure for 3 cycles in the middle of a streaming packet.
    for (int i = 0; i < 5; i++) begin
      pa[i] = 8'($urandom);
      pb[i] = 8'($urandom);
    end
    fork
      send_packet(5, 1'b1, 2, 0);
      begin
        waited = 0;
        do begin
          @(posedge clk);
          #1;
          waited++;
        end while (!out_valid && waited < 20);
        check("bp_seen_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b0;
        snap = out_data;
        repeat (3) begin
          @(posedge clk);
          #1;
          check("bp_in_ready", 32'(in_ready), 32'd0);
          check("bp_data", 32'(out_data), 32'(snap));
        end
        out_ready = 1'b1;
      end
    join
    repeat (2) @(posedge clk);
    #1;
    check("bp_drained", 32'(exp_q.size()), 32'd0);

    // Reset mid-packet with a carry pending.
    out_ready = 1'b0;
    send_word(8'hFF, 8'h01, 1'b0, 1'b0);
    srst = 1'b1;
    @(posedge clk);
    #1;
    check("srst_valid", 32'(out_valid), 32'd0);
    check("srst_data", 32'(out_data), 32'd0);
    check("srst_side", 32'({out_last, out_idx, out_cout, out_ovf}), 32'd0);
    srst = 1'b0;
    out_ready = 1'b1;
    pa[0] = 8'h01; pb[0] = 8'h01;
    send_packet(1, 1'b0, 0, 0);
    check("srst_new_data", 32'(out_data), 32'h02);
    check("srst_new_flags", 32'({out_idx, out_cout}), 32'b0000_0);

    // Random packets under random backpressure and idle gaps.
    rand_ready = 1'b1;
    for (int p = 0; p < 40; p++) begin
      int n;
      n = $urandom_range(1, 7);
      for (int i = 0; i < n; i++) begin
        pa[i] = 8'($urandom);
        pb[i] = 8'($urandom);
      end
      send_packet(n, logic'($urandom_range(0, 1)), 2, $urandom_range(0, 2));
    end
    // Long packet to exercise out_idx wrap.
    for (int i = 0; i < 18; i++) begin
      pa[i] = 8'($urandom);
      pb[i] = 8'h00;
    end
    send_packet(18, 1'b1, 2, 0);
    for (int i = 0; i < 18; i++) pa[i] = 8'($urandom);
    send_packet(18, 1'b0, 2, 1);

    rand_ready = 1'b0;
    out_ready  = 1'b1;
    waited = 0;
    while (exp_q.size() != 0 && waited < 100) begin
      @(posedge clk);
      waited++;
    end
    @(posedge clk);
    #1;
    check("final_drain", 32'(exp_q.size()), 32'd0);
    check("final_idle", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mpadd_seq.md
Name: mpadd_seq

Overview:
- Multi-precision sequential add/subtract engine. Consumes operand pairs as a stream of WIDTH-bit words, least-significant word first, and emits result words.
- Chains the carry/borrow between words internally through a carry register, so arbitrarily long integers run on one word-wide adder.
- Sits behind any stream source that splits wide operands into words. Feeds a result stream with a final carry-out and signed-overflow flag.

Parameters:
- WIDTH, 32, word width in bits (>=2).
- CNT_W, 4, width of the word-index counter reported on out_idx.

Ports:
- clk  input  1  clock
- srst  input  1  synchronous reset, active-high
- in_valid  input  1  operand word valid
- in_ready  output  1  engine accepts word this cycle
- in_a  input  WIDTH  operand A word
- in_b  input  WIDTH  operand B word
- in_last  input  1  final (most-significant) word of packet
- in_sub  input  1  1=A-B, 0=A+B; sampled on first word of packet only
- out_valid  output  1  result word valid
- out_ready  input  1  downstream accepts result
- out_data  output  WIDTH  result word
- out_last  output  1  result word is final word
- out_idx  output  CNT_W  word index within packet, 0 for first
- out_cout  output  1  carry-out of final word (1 = no borrow on subtract); valid only with out_last, else 0
- out_ovf  output  1  signed overflow of whole operation; valid only with out_last, else 0

Behaviour:
- Clock and reset: one clock, clk. Reset srst is synchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_last=0, out_idx=0, out_cout=0, out_ovf=0. Internally: carry=0, sub_r=0, cnt=0, state=FIRST.
- Handshake: in_ready = !out_valid || out_ready (single output register, no skid). Transfer occurs when in_valid && in_ready. Output transfers when out_valid && out_ready.
- Latency: one cycle. A word accepted at cycle N appears on out_* at N+1.
- FSM states:
  - FIRST: awaiting the first word of a packet.
  - MID: inside a packet.
- FSM transitions:
  - FIRST --accept, !in_last--> MID.
  - FIRST --accept, in_last--> FIRST (single-word packet).
  - MID --accept, in_last--> FIRST.
  - MID --accept, !in_last--> MID.
- Word arithmetic: b_eff = sub ? ~in_b : in_b. The sum is computed on WIDTH+1 bits: {0,in_a} + {0,b_eff} + cin.
  - sub is in_sub in FIRST, sub_r in MID. sub_r captures in_sub on first-word accept.
  - cin = in_sub in FIRST (two's-complement +1 for subtract), carry register in MID.
  - On accept, carry <= sum[WIDTH].
- out_idx: 0 on a first word, otherwise previous index +1. Wraps modulo 2**CNT_W with no error.
- Final word: out_cout = sum[WIDTH]. out_ovf = (in_a[MSB]==b_eff[MSB]) && (sum[MSB]!=in_a[MSB]). Both 0 on non-last words.
- in_sub toggling in MID is ignored.
- Backpressure: while out_valid && !out_ready, all out_* hold stable and in_ready=0. Accept and drain may occur in the same cycle (full throughput, one word per cycle).
- No input while out_ready=1: out_valid drops to 0 next cycle. out_data keeps its last value (don't-care).
- srst mid-packet: partial packet is discarded and any pending output is dropped. The next accepted word is treated as a first word, with carry cleared.

Decomposition:
- No shared package required. The state encoding (FIRST/MID) is a localparam inside the module.
- One natural sub-module, mpadd_word_add: combinational WIDTH-bit adder with sub/cin inputs. Outputs sum, cout and ovf. The top module holds the FSM, carry/sub registers, counter and output register.

Test Plan (WIDTH=8, CNT_W=4):
- Single word 0xFF+0x01, in_last=1, in_sub=0 -> out_data=0x00, out_last=1, out_cout=1, out_ovf=0, out_idx=0, one cycle after accept.
- Two-word add 0x01FF+0x0001 (words (FF,01) then (01,00)) -> out_data 0x00 idx0, then 0x02 idx1 with out_last=1, out_cout=0, out_ovf=0.
- Two-word subtract 0x0100-0x0001 (words (00,01),(01,00), in_sub=1 on first word, 0 on second) -> 0xFF idx0, 0x00 idx1, out_cout=1, out_ovf=0. The second word stays in subtract mode despite in_sub=0.
- Single word 0x7F+0x01 -> out_data=0x80, out_ovf=1, out_cout=0. Then 0x80-0x01 with in_sub=1 -> 0x7F, out_ovf=1, out_cout=1.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and out_* stable throughout. Release -> words stream back-to-back, no loss or duplication, continuous out_idx.
- srst asserted after first word of a two-word packet -> outputs reset next cycle. A new single-word 0x01+0x01 packet -> out_data=0x02, out_idx=0, out_cout=0, with no stale carry.
